prio_enc_rr: RTL and testbench

//   Parametrised N-input priority encoder with a registered valid/ready output stage and
//   run-time selectable fixed or round-robin priority.

---
 rtl/prio_enc_pkg.sv | 13 +
 rtl/prio_find.sv | 28 ++
 rtl/prio_enc_rr.sv | 99 +++++++++
 tb/tb_prio_enc_rr.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared mode encoding and index-width helper for the priority encoder
// Contents:
//   prio_mode_e  selects fixed priority (MODE_FIXED) or round-robin priority (MODE_RR)
//   idx_w(n)     index width for an n-entry vector, at least 1
package prio_enc_pkg;

    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} prio_mode_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_find.sv
// prio_find: combinational highest-set-bit finder
// Ports:
//   i_vec     in   N  vector to search
//   o_found   out  1  at least one bit of i_vec is set
//   o_idx     out  W  index of the highest set bit, 0 when none is set
//   o_onehot  out  N  one-hot form of o_idx, 0 when none is set
module prio_find
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] i_vec,
    output logic         o_found,
    output logic [W-1:0] o_idx,
    output logic [N-1:0] o_onehot
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        o_idx = '0;
        for (int k = 0; k < N; k++)
            if (i_vec[k]) o_idx = W'(k);
        o_found  = |i_vec;
        o_onehot = o_found ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/prio_enc_rr.sv
// prio_enc_rr: N-input priority encoder, fixed or round-robin, with a registered valid/ready output
// Ports:
//   clk_i        in   1  clock, rising edge
//   rst_i        in   1  asynchronous active-high reset
//   req_i        in   N  request vector
//   mode_i       in   1  0 = fixed (highest index wins), 1 = round-robin; sampled on accept
//   in_valid_i   in   1  req_i/mode_i valid
//   in_ready_o   out  1  block can accept this cycle
//   out_valid_o  out  1  result outputs valid
//   out_ready_i  in   1  consumer takes the result this cycle
//   idx_o        out  W  binary index of the winner
//   onehot_o     out  N  one-hot winner, 0 when none_o
//   none_o       out  1  accepted vector was all zero
module prio_enc_rr
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         mode_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o,
    output logic         none_o
);

    logic [W-1:0] r_ptr;
    logic         r_valid;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_onehot;
    logic         r_none;

    logic [N-1:0] w_mask;
    logic         w_m_found, w_f_found;
    logic [W-1:0] w_m_idx, w_f_idx, w_idx, w_ptr_nxt;
    logic [N-1:0] w_m_onehot, w_f_onehot, w_onehot;
    logic         w_rr, w_use_mask, w_accept;

    // Bits at or below the pointer are searched first in round-robin mode.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < N; k++)
            w_mask[k] = (W'(k) <= r_ptr);
    end

    prio_find #(.N(N)) u_find_masked (
        .i_vec    (req_i & w_mask),
        .o_found  (w_m_found),
        .o_idx    (w_m_idx),
        .o_onehot (w_m_onehot)
    );

    prio_find #(.N(N)) u_find_full (
        .i_vec    (req_i),
        .o_found  (w_f_found),
        .o_idx    (w_f_idx),
        .o_onehot (w_f_onehot)
    );

    assign w_rr       = (prio_mode_e'(mode_i) == MODE_RR);
    assign w_use_mask = w_rr && w_m_found;
    assign w_idx      = w_use_mask ? w_m_idx : w_f_idx;
    assign w_onehot   = w_use_mask ? w_m_onehot : w_f_onehot;
    // Next search starts just below the winner, wrapping from 0 to N-1.
    assign w_ptr_nxt  = (w_idx == '0) ? W'(N - 1) : w_idx - W'(1);

    assign in_ready_o = !r_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr    <= W'(N - 1);
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_none   <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_idx    <= w_idx;
            r_onehot <= w_onehot;
            r_none   <= !w_f_found;
            if (w_rr && w_f_found) r_ptr <= w_ptr_nxt;
        end else if (out_ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid_o = r_valid;
    assign idx_o       = r_idx;
    assign onehot_o    = r_onehot;
    assign none_o      = r_none;

endmodule

// File: tb/tb_prio_enc_rr.sv
// tb_prio_enc_rr: scoreboard bench for prio_enc_rr with N = 8
module tb_prio_enc_rr;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] oh;
        logic       none;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] req_i = '0;
    logic       mode_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [2:0] idx_o;
    logic [7:0] onehot_o;
    logic       none_o;

    int   checks = 0;
    int   failures = 0;
    int   mptr = 7;
    exp_t q[$];

    prio_enc_rr #(.N(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .mode_i      (mode_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .idx_o       (idx_o),
        .onehot_o    (onehot_o),
        .none_o      (none_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the search order directly instead of masking.
    function automatic exp_t model(input logic [7:0] r, input logic m);
        exp_t e = '0;
        logic hit = 1'b0;
        int k;
        for (int j = 0; j < 8; j++) begin
            k = m ? (mptr - j + 8) % 8 : 7 - j;
            if (r[k] && !hit) begin
                hit = 1'b1;
                e.idx = 3'(k);
                e.oh = 8'(1 << k);
            end
        end
        e.none = !hit;
        return e;
    endfunction

    // Inputs change just after a falling edge; handshakes are judged 1 ns later.
    task automatic step(input logic [7:0] r, input logic m, input logic v, input logic ordy);
        exp_t e;
        req_i = r;
        mode_i = m;
        in_valid_i = v;
        out_ready_i = ordy;
        #1;
        chk("in_ready", in_ready_o, (q.size() == 0) || ordy);
        chk("out_valid", out_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            chk("idx", idx_o, q[0].idx);
            chk("onehot", onehot_o, q[0].oh);
            chk("none", none_o, q[0].none);
            if (ordy) void'(q.pop_front());
        end
        if (v && in_ready_o) begin
            e = model(r, m);
            q.push_back(e);
            if (m && !e.none) mptr = (e.idx == 0) ? 7 : int'(e.idx) - 1;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ready", in_ready_o, 1);
        chk("rst_idx", idx_o, 0);
        chk("rst_onehot", onehot_o, 0);
        chk("rst_none", none_o, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) step(8'((9'd1 << (i + 1)) - 9'd1), 1'b0, 1'b1, 1'b1);
        step(8'hA5, 1'b0, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 9; i++) step(8'hFF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(8'h24, 1'b1, 1'b1, 1'b1);
        step(8'h24, 1'b0, 1'b1, 1'b1);
        step(8'h24, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 3; i++) step(8'hAA, 1'b1, 1'b1, 1'b0);
        step(8'hAA, 1'b1, 1'b1, 1'b1);
        step(8'h81, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 60; i++)
            step(8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));

        step(8'h3C, 1'b1, 1'b1, 1'b0);
        step(8'h0F, 1'b1, 1'b1, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        chk("async_valid", out_valid_o, 0);
        chk("async_idx", idx_o, 0);
        chk("async_onehot", onehot_o, 0);
        q.delete();
        mptr = 7;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        step(8'hFF, 1'b1, 1'b1, 1'b0);
        step(8'hFF, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 4 && q.size() != 0; i++) step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
